// File: rtl/player_action_fsm.sv
// Per-player movement/action sequencer: walk, jump physics, crouch,
// shield and a three-phase attack, all paced by the tick enable.
// Optional: define AIR_CONTROL_EN to allow left/right steering mid-jump.
module player_action_fsm #(
  parameter int X_INIT      = 300,
  parameter int Y_GROUND    = 300,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 600,
  parameter int WALK_STEP   = 1,
  parameter int JUMP_VEL    = 12,
  parameter int GRAVITY     = 1,
  parameter int ATK_WINDUP  = 4,
  parameter int ATK_ACTIVE  = 3,
  parameter int ATK_RECOVER = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [6:0] controller_inputs,
  output logic [9:0] player_x,
  output logic [9:0] player_y,
  output logic [2:0] action_state,
  output logic       attack_active,
  output logic       shield_active,
  output logic       facing_right
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WALK     = 3'd1,
    JUMP     = 3'd2,
    ATK_WIND = 3'd3,
    ATK_ACT  = 3'd4,
    ATK_REC  = 3'd5,
    SHIELD   = 3'd6,
    CROUCH   = 3'd7
  } state_e;

  localparam logic signed [10:0] XMIN_S = 11'(X_MIN);
  localparam logic signed [10:0] XMAX_S = 11'(X_MAX);
  localparam logic signed [10:0] STEP_S = 11'(WALK_STEP);
  localparam logic signed [10:0] YGND_S = 11'(Y_GROUND);

  state_e            state_q, state_d;
  logic [9:0]        x_q, x_d;
  logic [9:0]        y_q, y_d;
  logic signed [6:0] vel_q, vel_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              atk_prev_q, atk_prev_d;
  logic              facing_q, facing_d;
  logic              atk_act_q, atk_act_d;
  logic              shd_act_q, shd_act_d;

  logic btn_l, btn_r, btn_u, btn_d, btn_a, btn_s;
  logic atk_edge, step_l, step_r;
  logic signed [10:0] xs, xl, xr, ys, vs, yn;
  logic [9:0] x_left, x_right, x_walk;
  logic unused_in0;

  assign unused_in0 = controller_inputs[0];
  assign btn_l = controller_inputs[1];
  assign btn_r = controller_inputs[2];
  assign btn_u = controller_inputs[3];
  assign btn_d = controller_inputs[4];
  assign btn_a = controller_inputs[5];
  assign btn_s = controller_inputs[6];

  // Candidate positions: saturating horizontal steps and the next jump height.
  always_comb begin
    atk_edge = btn_a & ~atk_prev_q;
    step_l   = btn_l & ~btn_r;
    step_r   = btn_r & ~btn_l;
    xs       = $signed({1'b0, x_q});
    xl       = xs - STEP_S;
    xr       = xs + STEP_S;
    x_left   = (xl < XMIN_S) ? 10'(XMIN_S) : 10'(xl);
    x_right  = (xr > XMAX_S) ? 10'(XMAX_S) : 10'(xr);
    x_walk   = step_l ? x_left : (step_r ? x_right : x_q);
    ys       = $signed({1'b0, y_q});
    vs       = 11'(vel_q);
    yn       = ys - vs;
  end

  // Next-state and next-output logic; nothing moves without a tick.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    vel_d      = vel_q;
    cnt_d      = cnt_q;
    atk_prev_d = atk_prev_q;
    facing_d   = facing_q;
    if (tick) begin
      atk_prev_d = btn_a;
      unique case (state_q)
        IDLE, WALK, CROUCH, SHIELD: begin
          if (btn_s) begin
            state_d = SHIELD;
          end else if (atk_edge) begin
            state_d = ATK_WIND;
            cnt_d   = 8'(ATK_WINDUP - 1);
          end else if (btn_u) begin
            state_d = JUMP;
            vel_d   = 7'(JUMP_VEL);
`ifdef AIR_CONTROL_EN
            x_d = x_walk;
            if (step_l | step_r) facing_d = step_r;
`endif
          end else if (btn_d) begin
            state_d = CROUCH;
          end else if (step_l | step_r) begin
            state_d  = WALK;
            x_d      = x_walk;
            facing_d = step_r;
          end else begin
            state_d = IDLE;
          end
        end
        JUMP: begin
          if (yn >= YGND_S) begin
            state_d = IDLE;
            y_d     = 10'(YGND_S);
            vel_d   = '0;
          end else begin
            y_d   = (yn < 0) ? '0 : 10'(yn);
            vel_d = vel_q - 7'(GRAVITY);
          end
`ifdef AIR_CONTROL_EN
          x_d = x_walk;
          if (step_l | step_r) facing_d = step_r;
`endif
        end
        ATK_WIND: begin
          if (cnt_q == '0) begin
            state_d = ATK_ACT;
            cnt_d   = 8'(ATK_ACTIVE - 1);
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        ATK_ACT: begin
          if (cnt_q == '0) begin
            state_d = ATK_REC;
            cnt_d   = 8'(ATK_RECOVER - 1);
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        ATK_REC: begin
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    atk_act_d = (state_d == ATK_ACT);
    shd_act_d = (state_d == SHIELD);
  end

  // State and output registers with immediate asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      x_q        <= 10'(X_INIT);
      y_q        <= 10'(Y_GROUND);
      vel_q      <= '0;
      cnt_q      <= '0;
      atk_prev_q <= 1'b0;
      facing_q   <= 1'b1;
      atk_act_q  <= 1'b0;
      shd_act_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      vel_q      <= vel_d;
      cnt_q      <= cnt_d;
      atk_prev_q <= atk_prev_d;
      facing_q   <= facing_d;
      atk_act_q  <= atk_act_d;
      shd_act_q  <= shd_act_d;
    end
  end

  assign player_x      = x_q;
  assign player_y      = y_q;
  assign action_state  = state_q;
  assign attack_active = atk_act_q;
  assign shield_active = shd_act_q;
  assign facing_right  = facing_q;

endmodule

// File: tb/tb_player_action_fsm.sv
// Scoreboard bench for player_action_fsm: directed scenarios plus
// randomized controller input against a tick-level behavioural model.
module tb_player_action_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [6:0] ci = '0;
  logic [9:0] player_x, player_y;
  logic [2:0] action_state;
  logic       attack_active, shield_active, facing_right;

  always #5 clk = ~clk;

  player_action_fsm dut (
    .clk(clk), .rst(rst), .tick(tick), .controller_inputs(ci),
    .player_x(player_x), .player_y(player_y),
    .action_state(action_state), .attack_active(attack_active),
    .shield_active(shield_active), .facing_right(facing_right)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] st;
    logic       aa;
    logic       sa;
    logic       fr;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  event rst_ev;

  localparam logic [6:0] B_L = 7'b0000010;
  localparam logic [6:0] B_R = 7'b0000100;
  localparam logic [6:0] B_U = 7'b0001000;
  localparam logic [6:0] B_D = 7'b0010000;
  localparam logic [6:0] B_A = 7'b0100000;
  localparam logic [6:0] B_S = 7'b1000000;

  // Behavioural model: attack tracked by elapsed ticks, jump by closed form.
  int m_st, m_x, m_y, m_face, m_prev, m_at, m_jk;

  task automatic model_reset();
    m_st = 0; m_x = 300; m_y = 300; m_face = 1;
    m_prev = 0; m_at = 0; m_jk = 0;
  endtask

  task automatic model_move(input int dir);
    if (dir != 0) begin
      m_x = m_x + dir;
      if (m_x < 0) m_x = 0;
      if (m_x > 600) m_x = 600;
      m_face = (dir > 0) ? 1 : 0;
    end
  endtask

  task automatic model_step(input logic [6:0] in);
    int dir, h, ny;
    bit edge_a;
    edge_a = in[5] && !m_prev;
    m_prev = int'(in[5]);
    dir = (in[1] && !in[2]) ? -1 : ((in[2] && !in[1]) ? 1 : 0);
    if (m_st >= 3 && m_st <= 5) begin
      m_at++;
      if (m_at >= 13) m_st = 0;
      else m_st = (m_at < 4) ? 3 : ((m_at < 7) ? 4 : 5);
    end else if (m_st == 2) begin
      m_jk++;
      h  = m_jk * 12 - (m_jk * (m_jk - 1)) / 2;
      ny = 300 - h;
      if (ny >= 300) begin
        m_y = 300; m_st = 0;
      end else begin
        m_y = (ny < 0) ? 0 : ny;
      end
`ifdef AIR_CONTROL_EN
      model_move(dir);
`endif
    end else begin
      if (in[6]) m_st = 6;
      else if (edge_a) begin m_st = 3; m_at = 0; end
      else if (in[3]) begin
        m_st = 2; m_jk = 0;
`ifdef AIR_CONTROL_EN
        model_move(dir);
`endif
      end
      else if (in[4]) m_st = 7;
      else if (dir != 0) begin m_st = 1; model_move(dir); end
      else m_st = 0;
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.x  = 10'(m_x);
    o.y  = 10'(m_y);
    o.st = 3'(m_st);
    o.aa = (m_st == 4);
    o.sa = (m_st == 6);
    o.fr = (m_face != 0);
    return o;
  endfunction

  task automatic pop_check(input string nm);
    obs_t e, a;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: DUT output with no expected entry queued", nm);
    end else begin
      e = exp_q.pop_front();
      a = '{player_x, player_y, action_state,
            attack_active, shield_active, facing_right};
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got x=%0d y=%0d st=%0d aa=%0b sa=%0b fr=%0b want x=%0d y=%0d st=%0d aa=%0b sa=%0b fr=%0b",
                 nm, a.x, a.y, a.st, a.aa, a.sa, a.fr,
                 e.x, e.y, e.st, e.aa, e.sa, e.fr);
      end
    end
  endtask

  // Monitor: each tick edge the DUT presents a new output set.
  always @(posedge clk) begin
    if (tick && !rst) begin
      #1;
      pop_check("tick");
    end
  end

  always @(rst_ev) pop_check("reset");

  task automatic direct(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic do_tick(input logic [6:0] in);
    @(negedge clk);
    ci = in;
    model_step(in);
    exp_q.push_back(model_obs());
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    exp_q.push_back(model_obs());
    ->rst_ev;
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [6:0] r;
    int hold;
    model_reset();
    apply_reset();
    direct("reset_x", int'(player_x), 300);
    direct("reset_fr", int'(facing_right), 1);

    for (int i = 0; i < 10; i++) do_tick(B_R);
    direct("walk_x", int'(player_x), 310);
    direct("walk_y", int'(player_y), 300);
    direct("walk_st", int'(action_state), 1);
    direct("walk_fr", int'(facing_right), 1);
    do_tick('0);
    direct("release_st", int'(action_state), 0);

    for (int i = 0; i < 400 && m_x > 2; i++) do_tick(B_L);
    direct("left_x2", int'(player_x), 2);
    for (int i = 0; i < 5; i++) do_tick(B_L);
    direct("left_sat", int'(player_x), 0);
    direct("left_fr", int'(facing_right), 0);

    do_tick(B_U);
    direct("jump_st", int'(action_state), 2);
    for (int i = 1; i <= 25; i++) begin
      do_tick((i >= 3 && i <= 8) ? (B_A | B_S | B_D) : 7'd0);
      if (i == 12) direct("jump_apex", int'(player_y), 222);
      if (i == 24) direct("jump_air_st", int'(action_state), 2);
    end
    direct("land_y", int'(player_y), 300);
    direct("land_st", int'(action_state), 0);

    for (int i = 1; i <= 20; i++) begin
      do_tick(B_A);
      direct("atk_st", int'(action_state),
             (i <= 4) ? 3 : ((i <= 7) ? 4 : ((i <= 13) ? 5 : 0)));
      direct("atk_aa", int'(attack_active), (i >= 5 && i <= 7) ? 1 : 0);
    end
    do_tick('0);
    do_tick(B_A);
    direct("atk_retrig", int'(action_state), 3);
    for (int i = 0; i < 13; i++) do_tick('0);

    for (int i = 0; i < 3; i++) do_tick(B_S | B_R | B_A);
    direct("shield_st", int'(action_state), 6);
    direct("shield_sa", int'(shield_active), 1);
    direct("shield_x", int'(player_x), 0);
    do_tick(B_L | B_R);
    direct("lr_st", int'(action_state), 0);
    direct("lr_x", int'(player_x), 0);

    apply_reset();
    for (int i = 0; i < 20; i++) do_tick(B_R);
    do_tick('0);
    for (int i = 0; i < 5; i++) do_tick(B_A);
    direct("pre_rst_st", int'(action_state), 4);
    direct("pre_rst_x", int'(player_x), 320);
    apply_reset();
    direct("rst_st", int'(action_state), 0);
    direct("rst_aa", int'(attack_active), 0);
    direct("rst_x", int'(player_x), 300);

    for (int i = 0; i < 25; i++) do_tick(B_U | B_R);
`ifdef AIR_CONTROL_EN
    direct("air_x", int'(player_x), 325);
`else
    direct("air_x", int'(player_x), 300);
`endif
    for (int i = 0; i < 3; i++) do_tick('0);

    hold = 0;
    r = '0;
    for (int i = 0; i < 800; i++) begin
      if (hold == 0) begin
        r = '0;
        r[0] = 1'($urandom);
        r[1] = ($urandom_range(0, 2) == 0);
        r[2] = ($urandom_range(0, 2) == 0);
        r[3] = ($urandom_range(0, 7) == 0);
        r[4] = ($urandom_range(0, 7) == 0);
        r[5] = ($urandom_range(0, 4) == 0);
        r[6] = ($urandom_range(0, 9) == 0);
        hold = $urandom_range(1, 6);
      end
      hold--;
      do_tick(r);
      if ($urandom_range(0, 149) == 0) apply_reset();
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries never observed", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
